// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared FSM state encoding and default timing for the button
//               conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2
    } btn_state_t;

    localparam int c_DEBOUNCE_CYCLES = 250000;    // 10 ms at 25 MHz
    localparam int c_REPEAT_DELAY    = 12500000;  // 500 ms
    localparam int c_REPEAT_RATE     = 3750000;   // 150 ms

    // Counter width needed to hold 0 .. value-1, never less than one bit.
    function automatic int width_for(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Raw pushbutton inputs and conditioned game-control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;

    logic       btn_right_raw;
    logic       btn_left_raw;
    logic       btn_drop_raw;
    logic       move_right;
    logic       move_left;
    logic       drop_piece;
    logic [2:0] held;

    modport master (
        output btn_right_raw, btn_left_raw, btn_drop_raw,
        input  move_right, move_left, drop_piece, held
    );

    modport slave (
        input  btn_right_raw, btn_left_raw, btn_drop_raw,
        output move_right, move_left, drop_piece, held
    );

endinterface
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One pushbutton: 2-flop synchronizer, debounce, press/repeat FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int REPEAT_RATE     = c_REPEAT_RATE,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw,
    output logic      o_stable,
    output logic      o_pulse
);

    localparam int c_CW = width_for(DEBOUNCE_CYCLES);
    localparam int c_TW = width_for((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

    localparam logic [c_CW-1:0] c_DB_TERM    = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_DELAY_TERM = c_TW'(REPEAT_DELAY - 1);
    localparam logic [c_TW-1:0] c_RATE_TERM  = c_TW'(REPEAT_RATE - 1);

    logic [1:0]      r_sync;
    logic            r_stable;
    logic [c_CW-1:0] r_count;
    btn_state_t      r_state;
    logic [c_TW-1:0] r_timer;
    logic            r_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Any sample that agrees with the stable level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_count  <= '0;
        end else if (r_sync[1] == r_stable) begin
            r_count <= '0;
        end else if (r_count == c_DB_TERM) begin
            r_stable <= r_sync[1];
            r_count  <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RELEASED;
            r_timer <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                RELEASED: begin
                    r_timer <= '0;
                    if (r_stable) begin
                        r_state <= DELAY;
                        r_pulse <= 1'b1;
                    end
                end
                DELAY: begin
                    if (!r_stable) begin
                        r_state <= RELEASED;
                        r_timer <= '0;
                    end else if (REPEAT_EN) begin
                        if (r_timer == c_DELAY_TERM) begin
                            r_state <= REPEAT;
                            r_timer <= '0;
                            r_pulse <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!r_stable) begin
                        r_state <= RELEASED;
                        r_timer <= '0;
                    end else if (r_timer == c_RATE_TERM) begin
                        r_timer <= '0;
                        r_pulse <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign o_stable = r_stable;
    assign o_pulse  = r_pulse;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Three debounced pushbuttons with auto-repeat on left/right.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int REPEAT_RATE     = c_REPEAT_RATE
) (
    input  wire logic           clk_25MHz,
    input  wire logic           rst,
    button_conditioner_if.slave bus
);

    logic w_right_pulse, w_left_pulse, w_drop_pulse;
    logic w_right_stable, w_left_stable, w_drop_stable;

    logic       r_move_right;
    logic       r_move_left;
    logic       r_drop_piece;
    logic [2:0] r_held;

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE),
        .REPEAT_EN       (1'b1)
    ) u_right (
        .clk      (clk_25MHz),
        .rst      (rst),
        .i_raw    (bus.btn_right_raw),
        .o_stable (w_right_stable),
        .o_pulse  (w_right_pulse)
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE),
        .REPEAT_EN       (1'b1)
    ) u_left (
        .clk      (clk_25MHz),
        .rst      (rst),
        .i_raw    (bus.btn_left_raw),
        .o_stable (w_left_stable),
        .o_pulse  (w_left_pulse)
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE),
        .REPEAT_EN       (1'b0)
    ) u_drop (
        .clk      (clk_25MHz),
        .rst      (rst),
        .i_raw    (bus.btn_drop_raw),
        .o_stable (w_drop_stable),
        .o_pulse  (w_drop_pulse)
    );

    // Contradictory left+right moves cancel; drop is never arbitrated.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            r_move_right <= 1'b0;
            r_move_left  <= 1'b0;
            r_drop_piece <= 1'b0;
            r_held       <= 3'b000;
        end else begin
            r_move_right <= w_right_pulse & ~w_left_pulse;
            r_move_left  <= w_left_pulse & ~w_right_pulse;
            r_drop_piece <= w_drop_pulse;
            r_held       <= {w_drop_stable, w_left_stable, w_right_stable};
        end
    end

    assign bus.move_right = r_move_right;
    assign bus.move_left  = r_move_left;
    assign bus.drop_piece = r_drop_piece;
    assign bus.held       = r_held;

endmodule
`default_nettype wire
